reflet_bus_arbiter: RTL and testbench

Two-master arbiter that shares the microcontroller system bus (address, write data, write enable, read data) between the reflet CPU and a DMA-style secondary master. It sits between the CPU/power manager and the memory map (instruction ROM, data RAM, peripherals). It grants the DMA by stalling the CPU through its enable input, and it bounds DMA bursts so the CPU is never starved while it is awake.

---
 rtl/reflet_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_reflet_bus_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reflet_bus_arbiter.sv
// reflet_bus_arbiter
// Shares the system bus between the reflet CPU and a DMA-style secondary
// master. The DMA gets the bus by stalling the CPU through its enable. A DMA
// burst is limited to max_burst transfers while the CPU is awake, and there
// is no limit while the CPU sleeps.
//
// Ports
//   clk, reset                  clock and asynchronous active-high reset
//   cpu_addr/data_out/write_en  CPU side of the bus
//   cpu_enable_in               power-manager enable request (1 = awake)
//   cpu_enable                  gated enable delivered to the CPU
//   dma_req/addr/data_out/
//   dma_write_en                DMA request and transfer
//   dma_grant                   DMA owns the bus this cycle
//   dma_rvalid                  bus_data_in holds the previous DMA read
//   bus_addr/data_out/write_en  shared bus towards the memory map
//   bus_data_in                 memory read data; the masters take it directly

module reflet_bus_arbiter #(
    parameter int wordsize  = 16,
    parameter int max_burst = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [wordsize-1:0] cpu_addr,
    input  logic [wordsize-1:0] cpu_data_out,
    input  logic                cpu_write_en,
    input  logic                cpu_enable_in,
    output logic                cpu_enable,
    input  logic                dma_req,
    input  logic [wordsize-1:0] dma_addr,
    input  logic [wordsize-1:0] dma_data_out,
    input  logic                dma_write_en,
    output logic                dma_grant,
    output logic                dma_rvalid,
    output logic [wordsize-1:0] bus_addr,
    output logic [wordsize-1:0] bus_data_out,
    output logic                bus_write_en,
    input  logic [wordsize-1:0] bus_data_in
);

    typedef enum logic [1:0] {
        CPU_OWN,
        TO_DMA,
        DMA_OWN,
        TO_CPU
    } state_t;

    localparam logic [7:0] LastCount = 8'(max_burst - 1);

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       rvalid_q, rvalid_d;

    // Read data is routed straight to both masters outside this block, so the
    // arbiter never looks at it.
    logic unusedBusData;
    assign unusedBusData = ^bus_data_in;

    // State, burst counter and read-valid flag. Reset is asynchronous so a
    // burst is torn down immediately without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= CPU_OWN;
            count_q  <= 8'd0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Bus steering and next-state logic. The two one-cycle handover states
    // keep the previous owner's address on the bus with writes suppressed,
    // so that owner's last synchronous read can still complete.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        cpu_enable   = 1'b0;
        dma_grant    = 1'b0;
        bus_addr     = cpu_addr;
        bus_data_out = cpu_data_out;
        bus_write_en = 1'b0;

        case (state_q)
            CPU_OWN: begin
                cpu_enable   = cpu_enable_in;
                bus_write_en = cpu_write_en;
                if (dma_req) begin
                    state_d = TO_DMA;
                end
            end
            TO_DMA: begin
                count_d = 8'd0;
                state_d = DMA_OWN;
            end
            DMA_OWN: begin
                dma_grant    = 1'b1;
                bus_addr     = dma_addr;
                bus_data_out = dma_data_out;
                bus_write_en = dma_write_en & dma_req;
                if (!dma_req) begin
                    state_d = TO_CPU;
                end else if (count_q == LastCount) begin
                    // Last allowed transfer: hand back only if the CPU is
                    // awake; a sleeping CPU leaves the counter saturated here.
                    if (cpu_enable_in) begin
                        state_d = TO_CPU;
                    end
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            TO_CPU: begin
                bus_addr     = dma_addr;
                bus_data_out = dma_data_out;
                state_d      = CPU_OWN;
            end
            default: begin
                state_d = CPU_OWN;
            end
        endcase
    end

    // A granted read is answered by the memory one cycle later.
    assign rvalid_d   = dma_grant & dma_req & ~dma_write_en;
    assign dma_rvalid = rvalid_q;

endmodule

// File: tb/tb_reflet_bus_arbiter.sv
// Self-checking bench for reflet_bus_arbiter. A small synchronous RAM plays
// the memory map; a reference model tracks bus ownership in terms of who owns
// the bus, whether a handover gap is in progress, and how many transfers the
// current grant has made.

module tb_reflet_bus_arbiter;

    localparam int MaxBurst = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr, cpu_data_out;
    logic        cpu_write_en, cpu_enable_in, cpu_enable;
    logic        dma_req;
    logic [15:0] dma_addr, dma_data_out;
    logic        dma_write_en, dma_grant, dma_rvalid;
    logic [15:0] bus_addr, bus_data_out, bus_data_in;
    logic        bus_write_en;

    int compareCount  = 0;
    int mismatchCount = 0;

    // Values captured at the most recent negedge sample.
    logic        obsGrant, obsCpuEn, obsWe, obsRvalid;
    logic [15:0] obsAddr, obsData, obsDataIn;

    // Reference model state.
    bit modelDma;
    bit modelGap;
    int modelXfers;
    bit modelRvalid;

    reflet_bus_arbiter #(.wordsize(16), .max_burst(MaxBurst)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_addr     (cpu_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_write_en (cpu_write_en),
        .cpu_enable_in(cpu_enable_in),
        .cpu_enable   (cpu_enable),
        .dma_req      (dma_req),
        .dma_addr     (dma_addr),
        .dma_data_out (dma_data_out),
        .dma_write_en (dma_write_en),
        .dma_grant    (dma_grant),
        .dma_rvalid   (dma_rvalid),
        .bus_addr     (bus_addr),
        .bus_data_out (bus_data_out),
        .bus_write_en (bus_write_en),
        .bus_data_in  (bus_data_in)
    );

    always #5 clk = ~clk;

    // Memory map stand-in: 256 words, synchronous read, word 0 preloaded
    // with 16'h1234 while reset is held.
    logic [15:0] ram [0:255];
    logic [15:0] ramRead;
    assign bus_data_in = ramRead;
    always @(posedge clk) begin
        if (reset) begin
            ram[0] <= 16'h1234;
        end else if (bus_write_en) begin
            ram[bus_addr[7:0]] <= bus_data_out;
        end
        ramRead <= ram[bus_addr[7:0]];
    end

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        modelDma    = 1'b0;
        modelGap    = 1'b0;
        modelXfers  = 0;
        modelRvalid = 1'b0;
    endtask

    // Compare all outputs against what the ownership model says the bus
    // should look like for the current inputs.
    task automatic checkModel();
        logic        expGrant, expCpuEn, expWe;
        logic [15:0] expAddr;
        expGrant = modelDma && !modelGap;
        if (!modelDma && !modelGap) begin
            expCpuEn = cpu_enable_in;
            expAddr  = cpu_addr;
            expWe    = cpu_write_en;
        end else if (!modelDma) begin
            expCpuEn = 1'b0;
            expAddr  = cpu_addr;
            expWe    = 1'b0;
        end else if (!modelGap) begin
            expCpuEn = 1'b0;
            expAddr  = dma_addr;
            expWe    = dma_write_en & dma_req;
        end else begin
            expCpuEn = 1'b0;
            expAddr  = dma_addr;
            expWe    = 1'b0;
        end
        checkOutput("grant", 32'(dma_grant), 32'(expGrant));
        checkOutput("cpuEnable", 32'(cpu_enable), 32'(expCpuEn));
        checkOutput("busAddr", 32'(bus_addr), 32'(expAddr));
        checkOutput("busWriteEn", 32'(bus_write_en), 32'(expWe));
        checkOutput("rvalid", 32'(dma_rvalid), 32'(modelRvalid));
        if (!modelGap) begin
            checkOutput("busData", 32'(bus_data_out),
                        32'(modelDma ? dma_data_out : cpu_data_out));
        end
    endtask

    // Advance the model across one clock edge using the inputs held there.
    task automatic modelEdge();
        bit granted;
        granted     = modelDma && !modelGap;
        modelRvalid = granted && dma_req && !dma_write_en;
        if (!modelDma) begin
            if (modelGap) begin
                modelDma   = 1'b1;
                modelGap   = 1'b0;
                modelXfers = 0;
            end else if (dma_req) begin
                modelGap = 1'b1;
            end
        end else begin
            if (modelGap) begin
                modelDma = 1'b0;
                modelGap = 1'b0;
            end else if (!dma_req) begin
                modelGap = 1'b1;
            end else begin
                modelXfers++;
                if (cpu_enable_in && modelXfers >= MaxBurst) begin
                    modelGap = 1'b1;
                end
            end
        end
    endtask

    // One full cycle: drive inputs just after a posedge, sample and check at
    // the negedge, then step the model over the next posedge.
    task automatic applyStimulus(input bit req, input bit dWe, input logic [15:0] dAddr,
                                 input logic [15:0] dData, input bit cpuEn,
                                 input logic [15:0] cAddr, input logic [15:0] cData,
                                 input bit cWe);
        dma_req       = req;
        dma_write_en  = dWe;
        dma_addr      = dAddr;
        dma_data_out  = dData;
        cpu_enable_in = cpuEn;
        cpu_addr      = cAddr;
        cpu_data_out  = cData;
        cpu_write_en  = cWe;
        @(negedge clk);
        obsGrant  = dma_grant;
        obsCpuEn  = cpu_enable;
        obsWe     = bus_write_en;
        obsRvalid = dma_rvalid;
        obsAddr   = bus_addr;
        obsData   = bus_data_out;
        obsDataIn = bus_data_in;
        checkModel();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    // DMA-only cycle with the CPU idle on a fixed address.
    task automatic dmaStep(input bit req, input bit dWe, input logic [15:0] dAddr,
                           input logic [15:0] dData, input bit cpuEn);
        applyStimulus(req, dWe, dAddr, dData, cpuEn, 16'h0004, 16'h0000, 1'b0);
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios first, then a long randomized run.
    initial begin
        int lowCount;
        int weCount;
        bit cen;
        bit expBit;

        reset         = 1'b1;
        dma_req       = 1'b1;
        dma_write_en  = 1'b0;
        dma_addr      = 16'h8000;
        dma_data_out  = 16'h0000;
        cpu_enable_in = 1'b1;
        cpu_addr      = 16'h0042;
        cpu_data_out  = 16'h0000;
        cpu_write_en  = 1'b0;
        modelReset();

        // Reset held with a pending DMA request.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstGrant", 32'(dma_grant), 32'd0);
        checkOutput("rstCpuEn", 32'(cpu_enable), 32'd1);
        checkOutput("rstBusAddr", 32'(bus_addr), 32'h0042);
        checkOutput("rstRvalid", 32'(dma_rvalid), 32'd0);
        reset = 1'b0;
        modelReset();
        dmaStep(1'b1, 1'b0, 16'h8000, 16'h0000, 1'b1);
        checkOutput("rstLat0", 32'(obsGrant), 32'd0);
        dmaStep(1'b1, 1'b0, 16'h8000, 16'h0000, 1'b1);
        checkOutput("rstLat1", 32'(obsGrant), 32'd0);
        dmaStep(1'b1, 1'b0, 16'h8000, 16'h0000, 1'b1);
        checkOutput("rstLat2", 32'(obsGrant), 32'd1);
        dmaStep(1'b0, 1'b0, 16'h8000, 16'h0000, 1'b1);
        dmaStep(1'b0, 1'b0, 16'h8000, 16'h0000, 1'b1);

        // Single DMA write, then CPU readback of the same word.
        lowCount = 0;
        weCount  = 0;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0, 1: dmaStep(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1);
                2:    dmaStep(1'b1, 1'b1, 16'h8010, 16'hBEEF, 1'b1);
                3, 4: dmaStep(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
                default: applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1,
                                       16'h8010, 16'h0000, 1'b0);
            endcase
            if (!obsCpuEn) lowCount++;
            if (obsWe) weCount++;
            if (i == 2) begin
                checkOutput("wrAddr", 32'(obsAddr), 32'h8010);
                checkOutput("wrData", 32'(obsData), 32'hBEEF);
                checkOutput("wrWe", 32'(obsWe), 32'd1);
            end
            if (i == 3) checkOutput("wrNoRvalid", 32'(obsRvalid), 32'd0);
        end
        checkOutput("wrCpuLowCycles", 32'(lowCount), 32'd4);
        checkOutput("wrWeCycles", 32'(weCount), 32'd1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0004, 16'h0000, 1'b0);
        checkOutput("cpuReadback", 32'(obsDataIn), 32'hBEEF);

        // DMA read of the preloaded word.
        dmaStep(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1);
        dmaStep(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1);
        dmaStep(1'b1, 1'b0, 16'h8000, 16'h0000, 1'b1);
        dmaStep(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        checkOutput("rdRvalid", 32'(obsRvalid), 32'd1);
        checkOutput("rdData", 32'(obsDataIn), 32'h1234);
        dmaStep(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);

        // Burst limit with the CPU awake: 8 grants, 3-cycle gap, repeat.
        for (int i = 0; i < 24; i++) begin
            int k;
            dmaStep(1'b1, 1'b0, 16'($urandom), 16'h0000, 1'b1);
            k = i - 2;
            expBit = (i >= 2) && (k % 11 < 8);
            checkOutput("burstGrant", 32'(obsGrant), 32'(expBit));
            expBit = (i == 0) || ((i >= 2) && (k % 11 == 9));
            checkOutput("burstCpuEn", 32'(obsCpuEn), 32'(expBit));
        end
        repeat (4) dmaStep(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);

        // Sleeping CPU: no forced handover.
        for (int i = 0; i < 32; i++) begin
            dmaStep(1'b1, 1'($urandom), 16'($urandom), 16'($urandom), 1'b0);
            checkOutput("sleepGrant", 32'(obsGrant), 32'(i >= 2));
        end
        repeat (4) dmaStep(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);

        // Reset in the third granted write of a burst.
        repeat (4) dmaStep(1'b1, 1'b1, 16'h8020, 16'h5555, 1'b1);
        dma_req       = 1'b1;
        dma_write_en  = 1'b1;
        dma_addr      = 16'h8022;
        cpu_enable_in = 1'b1;
        cpu_write_en  = 1'b0;
        #2;
        checkOutput("midGrantBefore", 32'(dma_grant), 32'd1);
        checkOutput("midWeBefore", 32'(bus_write_en), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("midGrantAsync", 32'(dma_grant), 32'd0);
        checkOutput("midWeAsync", 32'(bus_write_en), 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 11; i++) begin
            dmaStep(1'b1, 1'b0, 16'h8000, 16'h0000, 1'b1);
            if (i == 9) checkOutput("postRstLastXfer", 32'(obsGrant), 32'd1);
            if (i == 10) checkOutput("postRstBurstEnd", 32'(obsGrant), 32'd0);
        end
        repeat (4) dmaStep(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);

        // Randomized traffic with varying request density and CPU sleep.
        cen = 1'b1;
        for (int i = 0; i < 600; i++) begin
            int density;
            case ((i / 100) % 3)
                0:       density = 9;
                1:       density = 5;
                default: density = 2;
            endcase
            if ($urandom_range(0, 19) == 0) cen = ~cen;
            applyStimulus($urandom_range(0, 9) < density, 1'($urandom),
                          16'($urandom), 16'($urandom), cen,
                          16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
